// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int n = 32
);
    logic         i_req;
    logic [n-1:0] i_addr;
    logic [n-1:0] i_rdata;
    logic         i_ready;
    logic         d_req;
    logic         d_we;
    logic [n-1:0] d_addr;
    logic [n-1:0] d_wdata;
    logic [n-1:0] d_rdata;
    logic         d_ready;
    logic         m_en;
    logic         m_we;
    logic [n-1:0] m_addr;
    logic [n-1:0] m_wdata;
    logic [n-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data to single-port memory arbiter with starvation guard
module mem_arbiter #(
    parameter int n       = 32,
    parameter int LAT     = 2,
    parameter int MAXWAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SW = $clog2(MAXWAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] acc_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_d;
    logic          pick_i;

    // Data wins a collision unless fetch has already waited MAXWAIT data grants.
    assign pick_i = bus.i_req && (!bus.d_req || (starve_cnt == SW'(MAXWAIT)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc_cnt     <= '0;
            starve_cnt  <= '0;
            grant_d     <= 1'b0;
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        // The memory-side registers double as the latched request fields.
                        if (pick_i) begin
                            grant_d    <= 1'b0;
                            bus.m_addr <= bus.i_addr;
                            bus.m_we   <= 1'b0;
                            starve_cnt <= '0;
                        end else begin
                            grant_d     <= 1'b1;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            bus.m_we    <= bus.d_we;
                            if (bus.i_req && (starve_cnt != SW'(MAXWAIT)))
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                        bus.m_en <= 1'b1;
                        acc_cnt  <= CW'(LAT - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (acc_cnt == '0) begin
                        if (!grant_d) begin
                            bus.i_rdata <= bus.m_rdata;
                            bus.i_ready <= 1'b1;
                        end else begin
                            if (!bus.m_we)
                                bus.d_rdata <= bus.m_rdata;
                            bus.d_ready <= 1'b1;
                        end
                        bus.m_en <= 1'b0;
                        bus.m_we <= 1'b0;
                        state    <= RESP;
                    end else begin
                        acc_cnt <= acc_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - transaction-level model and directed tests for mem_arbiter
module tb_mem_arbiter;
    localparam int LAT     = 2;
    localparam int MAXWAIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.n(32)) bus();
    mem_arbiter #(.n(32), .LAT(LAT), .MAXWAIT(MAXWAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          d;
        int          lat;
        logic [31:0] rdata;
    } done_t;

    req_t  iq[$];
    req_t  dq[$];
    done_t comp[$];

    logic [31:0] mem [256];
    assign bus.m_rdata = mem[bus.m_addr[7:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd    = 1'b1;
    int i_start = 0;
    int d_start = 0;

    // Transaction model: one record of the transaction in flight, with time measured from grant.
    bit          known = 1'b0;
    bit          act   = 1'b0;
    bit          t_d   = 1'b0;
    bit          t_we  = 1'b0;
    int          c0    = 0;
    int          starve = 0;
    logic [31:0] t_addr = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", nm, got, want, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        int s;
        bit gi;
        s = cyc;
        cyc++;
        if (reset) begin
            known = 1'b1; act = 1'b0; starve = 0;
            exp_i = '0; exp_d = '0; last_addr = '0; last_wdata = '0;
        end else begin
            if (act && s == c0 + LAT) begin
                if (!t_d)       exp_i = mem[t_addr[7:0]];
                else if (!t_we) exp_d = mem[t_addr[7:0]];
            end
            if (!act || s >= c0 + LAT + 2) begin
                act = 1'b0;
                if (bus.i_req || bus.d_req) begin
                    gi = (bus.i_req && bus.d_req) ? (starve == MAXWAIT) : bus.i_req;
                    if (gi) begin
                        t_d = 1'b0; t_we = 1'b0; t_addr = bus.i_addr;
                        starve = 0;
                    end else begin
                        t_d = 1'b1; t_we = bus.d_we; t_addr = bus.d_addr;
                        last_wdata = bus.d_wdata;
                        if (bus.i_req && starve < MAXWAIT) starve++;
                    end
                    last_addr = t_addr;
                    c0  = s;
                    act = 1'b1;
                end
            end
        end
        if (bus.m_en === 1'b1 && bus.m_we === 1'b1) mem[bus.m_addr[7:0]] = bus.m_wdata;
    end

    always @(negedge clk) begin : compare
        int k;
        bit en;
        if (known) begin
            k  = cyc - c0;
            en = act && k >= 1 && k <= LAT;
            chk("m_en",    bus.m_en,    en);
            chk("m_we",    bus.m_we,    en && t_d && t_we);
            chk("m_addr",  bus.m_addr,  last_addr);
            chk("m_wdata", bus.m_wdata, last_wdata);
            chk("i_ready", bus.i_ready, act && k == LAT + 1 && !t_d);
            chk("d_ready", bus.d_ready, act && k == LAT + 1 && t_d);
            chk("i_rdata", bus.i_rdata, exp_i);
            chk("d_rdata", bus.d_rdata, exp_d);
        end
    end

    // Requesters: hold the head of each queue until its ready pulse, then move on.
    always @(negedge clk) begin : driver
        if (rnd) begin
            bus.i_req   = 1'($urandom);
            bus.i_addr  = $urandom;
            bus.d_req   = 1'($urandom);
            bus.d_we    = 1'($urandom);
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end else begin
            if (reset) begin
                iq.delete();
                dq.delete();
            end
            if (bus.i_ready && iq.size() > 0) begin
                comp.push_back('{d: 1'b0, lat: cyc - i_start, rdata: bus.i_rdata});
                void'(iq.pop_front());
                i_start = cyc + 1;
            end
            if (bus.d_ready && dq.size() > 0) begin
                comp.push_back('{d: 1'b1, lat: cyc - d_start, rdata: bus.d_rdata});
                void'(dq.pop_front());
                d_start = cyc + 1;
            end
            if (iq.size() > 0) begin
                if (!bus.i_req) i_start = cyc;
                bus.i_req  = 1'b1;
                bus.i_addr = iq[0].addr;
            end else begin
                bus.i_req = 1'b0;
            end
            if (dq.size() > 0) begin
                if (!bus.d_req) d_start = cyc;
                bus.d_req   = 1'b1;
                bus.d_we    = dq[0].we;
                bus.d_addr  = dq[0].addr;
                bus.d_wdata = dq[0].wdata;
            end else begin
                bus.d_req = 1'b0;
            end
        end
    end

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles", nm, budget);
            iq.delete();
            dq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    bit exp_ord [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[8'h10] = 32'hDEADBEEF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rnd   = 1'b0;
        chk("rst_m_en",    bus.m_en,    0);
        chk("rst_m_addr",  bus.m_addr,  0);
        chk("rst_i_ready", bus.i_ready, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);

        // Instruction read
        @(posedge clk); #1;
        comp.delete();
        iq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        wait_done("iread", 40);
        chk("iread_n", comp.size(), 1);
        if (comp.size() >= 1) begin
            chk("iread_lat",   comp[0].lat,   3);
            chk("iread_rdata", comp[0].rdata, 32'hDEADBEEF);
        end

        // Data write
        comp.delete();
        dq.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h12345678});
        wait_done("dwrite", 40);
        chk("dwrite_n", comp.size(), 1);
        if (comp.size() >= 1) begin
            chk("dwrite_lat",   comp[0].lat,   3);
            chk("dwrite_rdata", comp[0].rdata, 0);
        end
        chk("dwrite_mem", mem[8'h40], 32'h12345678);

        // Collision: data first, fetch follows
        comp.delete();
        dq.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        iq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        wait_done("collide", 60);
        chk("collide_n", comp.size(), 2);
        if (comp.size() >= 2) begin
            chk("collide_first_d", comp[0].d,     1);
            chk("collide_d_lat",   comp[0].lat,   3);
            chk("collide_d_rdata", comp[0].rdata, 32'h12345678);
            chk("collide_i_lat",   comp[1].lat,   7);
            chk("collide_i_rdata", comp[1].rdata, 32'hA500_0020);
        end

        // Starvation guard
        comp.delete();
        for (int j = 0; j < 6; j++)
            dq.push_back('{we: 1'(j % 2), addr: 32'h50 + j, wdata: 32'hC0DE_0000 + j});
        iq.push_back('{we: 1'b0, addr: 32'h11, wdata: 32'h0});
        iq.push_back('{we: 1'b0, addr: 32'h12, wdata: 32'h0});
        wait_done("starve", 120);
        chk("starve_n", comp.size(), 8);
        if (comp.size() >= 8)
            for (int j = 0; j < 8; j++) chk($sformatf("starve_order%0d", j), comp[j].d, exp_ord[j]);

        // Reset during the first access cycle of a data read
        comp.delete();
        dq.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0});
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_ready", comp.size(), 0);
        chk("abort_d_rdata",  bus.d_rdata, 0);
        iq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        wait_done("post_rst", 40);
        chk("post_rst_n", comp.size(), 1);
        if (comp.size() >= 1) begin
            chk("post_rst_lat",   comp[0].lat,   3);
            chk("post_rst_rdata", comp[0].rdata, 32'hDEADBEEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to single-port memory arbiter that lets the CPU's instruction-fetch path and data path share one unified main memory with multi-cycle access latency. Each requester has a req/ready handshake. The arbiter picks one requester, drives the memory port for a fixed number of cycles, captures the result and returns it with a one-cycle ready pulse. Data accesses have priority, and a starvation counter guarantees instruction fetches forward progress.

## Interface

Parameters:
- n, 32 (`WORDSIZE`): data and address width.
- LAT, 2: memory access cycles per transaction (≥1).
- MAXWAIT, 4: maximum consecutive data grants while an instruction request is pending (≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  n  fetch address.
- i_rdata  out  n  fetched word; valid when i_ready=1.
- i_ready  out  1  one-cycle completion pulse, fetch port.
- d_req  in  1  data access request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  n  data address.
- d_wdata  in  n  write data.
- d_rdata  out  n  read word; valid when d_ready=1 after a read.
- d_ready  out  1  one-cycle completion pulse, data port.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  n  memory address.
- m_wdata  out  n  memory write data.
- m_rdata  in  n  memory read data, valid during the last access cycle.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - No req: stay in IDLE.
  - Any req: register the grant (G = I or D), latch that requester's addr/we/wdata, load the access counter with LAT-1, go to ACCESS.
- Grant rule
  - Only one req high: grant that requester.
  - Both high: grant I if starve_cnt == MAXWAIT, else grant D.
- starve_cnt
  - Increments (saturating at MAXWAIT) on a D grant made while i_req=1.
  - Clears on every I grant.
  - Otherwise unchanged.
- ACCESS
  - m_en=1. m_addr and m_wdata come from the latched values.
  - m_we is the latched d_we for D grants and 0 for I grants.
  - All memory outputs are held stable for exactly LAT cycles. The counter decrements each cycle.
  - When the counter reaches 0, capture m_rdata on reads and go to RESP.
- RESP
  - m_en=0, m_we=0.
  - Pulse the granted port's ready for one cycle.
  - Update the granted port's rdata register with the captured word. D writes leave d_rdata unchanged.
  - Return to IDLE.
- Requester protocol
  - A requester holds req, addr, we and wdata stable from assertion until its ready pulse.
  - req high in the cycle after ready counts as a new request.
  - The arbiter latches request fields at grant, so changes during ACCESS have no effect.
- Outputs
  - i_rdata and d_rdata hold their last value between completions.
  - The ungranted port's ready stays 0.
  - m_addr and m_wdata hold their last value while idle.
- Writes: memory may commit the same write on every ACCESS edge (idempotent).

## Timing

- Reset (sync) values: state=IDLE; starve_cnt=0; access counter=0; i_ready=d_ready=0; m_en=m_we=0; m_addr=m_wdata=0; i_rdata=d_rdata=0.
- Latency:
  - req sampled high in IDLE at cycle 0.
  - m_en=1 in cycles 1..LAT.
  - ready=1 in cycle LAT+1.
  - IDLE again in cycle LAT+2.
- Throughput: one transaction per LAT+2 cycles. No pipelining.
- Simultaneous i_req and d_req in IDLE: resolved only by the grant rule. The losing request stays pending, unacknowledged.
- Reset mid-ACCESS or mid-RESP:
  - Abort the transaction; no ready is issued.
  - m_en=0 in the next cycle.
  - A write may already have committed.
- LAT=1: ACCESS lasts one cycle; read data is captured that same cycle.

## Test plan

- Reset: assert reset 2 cycles with random inputs -> all outputs 0 and m_en=0 every cycle after reset.
- I read (LAT=2): i_req, i_addr=0x10, memory returns 0xDEADBEEF -> m_en=1, m_addr=0x10, m_we=0 in cycles 1-2; i_ready=1 with i_rdata=0xDEADBEEF in cycle 3; d_ready=0 throughout.
- D write: d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> m_en=m_we=1 with address/data stable in cycles 1-2; d_ready in cycle 3; d_rdata unchanged.
- Collision: i_req and d_req both rise at cycle 0; D drops after its ready -> D served (d_ready cycle 3), I granted in cycle 4 (i_ready cycle 7).
- Starvation (MAXWAIT=4): i_req and d_req held high continuously -> 4 D completions, then an I completion on the 5th transaction with starve_cnt back to 0, then D resumes.
- Reset during ACCESS cycle 1 of a D read -> no d_ready; m_en=0 next cycle. A subsequent I read completes with the normal cycle-3 latency.
